// File: rtl/nibbler_ram_arbiter_pkg.sv
// Shared types and sizes for the Nibbler data-RAM arbiter.
package nibbler_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 4;
  localparam int LEN_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/nibbler_ram_arbiter_if.sv
// CPU, debug-port and RAM-macro signals seen by the arbiter; slave is the arbiter's view.
interface nibbler_ram_arbiter_if #(
  parameter int ADDR_W = nibbler_pkg::ADDR_W,
  parameter int DATA_W = nibbler_pkg::DATA_W,
  parameter int LEN_W  = nibbler_pkg::LEN_W
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_stall;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [LEN_W-1:0]  dbg_len;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_wready;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_busy;
  logic              dbg_done;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_stall, cpu_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_len, dbg_wdata,
    output dbg_wready, dbg_rvalid, dbg_rdata, dbg_busy, dbg_done,
    output ram_addr, ram_we, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_stall, cpu_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_len, dbg_wdata,
    input  dbg_wready, dbg_rvalid, dbg_rdata, dbg_busy, dbg_done,
    input  ram_addr, ram_we, ram_wdata,
    output ram_rdata
  );

endinterface

// File: rtl/nibbler_ram_arbiter_burst_ctr.sv
// Debug burst address (wraps at the top of RAM) and remaining-beat down-counter.
module nibbler_burst_ctr #(
  parameter int ADDR_W = nibbler_pkg::ADDR_W,
  parameter int LEN_W  = nibbler_pkg::LEN_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_step,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W:0]    r_remaining;

  // A zero length encodes the full 2**LEN_W beats, hence the extra counter bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_addr      <= '0;
      r_remaining <= '0;
    end else if (i_load) begin
      r_addr      <= i_addr;
      r_remaining <= (i_len == '0) ? {1'b1, LEN_W'(0)} : {1'b0, i_len};
    end else if (i_step) begin
      r_addr      <= r_addr + ADDR_W'(1);
      r_remaining <= r_remaining - (LEN_W + 1)'(1);
    end
  end

  assign o_addr = r_addr;
  assign o_last = (r_remaining == (LEN_W + 1)'(1));

endmodule

// File: rtl/nibbler_ram_arbiter.sv
// Shares the Nibbler data RAM between the CPU (fixed priority) and a debug burst port.
//   state | meaning
//   IDLE  | no burst; dbg_req starts one (no beat in the start cycle)
//   RUN   | burst active; beats when CPU idle or CPU starved debug too long
//   DONE  | one-cycle dbg_done pulse, then IDLE
module nibbler_ram_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = nibbler_pkg::ADDR_W,
  parameter int DATA_W       = nibbler_pkg::DATA_W
) (
  input  logic                  clock,
  input  logic                  reset,
  nibbler_ram_arbiter_if.slave  bus
);
  import nibbler_pkg::*;

  localparam int STARVE_W = ($clog2(STARVE_LIMIT + 1) < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  arb_state_e          r_state;
  arb_state_e          w_state_nxt;
  logic                r_dir;
  logic [STARVE_W-1:0] r_starve_cnt;
  logic                r_rvalid;
  logic [DATA_W-1:0]   r_rdata;

  logic [ADDR_W-1:0]   w_cur_addr;
  logic                w_last;
  logic                w_run;
  logic                w_force;
  logic                w_beat;
  logic                w_load;
  logic                w_gnt;

  assign w_run   = (r_state == ST_RUN);
  assign w_force = w_run && (r_starve_cnt == STARVE_W'(STARVE_LIMIT));
  assign w_beat  = reset && w_run && (!bus.cpu_req || w_force);
  assign w_load  = (r_state == ST_IDLE) && bus.dbg_req;
  assign w_gnt   = reset && bus.cpu_req && !w_force;

  nibbler_burst_ctr #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_burst_ctr (
    .clock  (clock),
    .reset  (reset),
    .i_load (w_load),
    .i_addr (bus.dbg_addr),
    .i_len  (bus.dbg_len),
    .i_step (w_beat),
    .o_addr (w_cur_addr),
    .o_last (w_last)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    bus.cpu_gnt    = 1'b0;
    bus.cpu_stall  = 1'b0;
    bus.cpu_rdata  = '0;
    bus.dbg_wready = 1'b0;
    bus.ram_addr   = '0;
    bus.ram_we     = 1'b0;
    bus.ram_wdata  = '0;

    case (r_state)
      ST_IDLE: if (bus.dbg_req) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_beat && w_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase

    // While reset is low every bus output is held at zero.
    if (reset) begin
      bus.cpu_gnt   = w_gnt;
      bus.cpu_stall = bus.cpu_req && w_force;
      bus.cpu_rdata = bus.ram_rdata;
      if (w_beat) begin
        bus.ram_addr   = w_cur_addr;
        bus.ram_we     = r_dir;
        bus.ram_wdata  = bus.dbg_wdata;
        bus.dbg_wready = r_dir;
      end else begin
        bus.ram_addr  = bus.cpu_addr;
        bus.ram_we    = w_gnt && bus.cpu_we;
        bus.ram_wdata = bus.cpu_wdata;
      end
    end
  end

  // Starve count only grows on blocked beats, so it stops at STARVE_LIMIT.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_dir        <= 1'b0;
      r_starve_cnt <= '0;
      r_rvalid     <= 1'b0;
      r_rdata      <= '0;
    end else begin
      r_rvalid <= w_beat && !r_dir;
      if (w_beat && !r_dir) r_rdata <= bus.ram_rdata;
      if (w_load) begin
        r_dir        <= bus.dbg_we;
        r_starve_cnt <= '0;
      end else if (w_beat) begin
        r_starve_cnt <= '0;
      end else if (w_run && bus.cpu_req) begin
        r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
      end
    end
  end

  assign bus.dbg_rvalid = r_rvalid;
  assign bus.dbg_rdata  = r_rdata;
  assign bus.dbg_busy   = w_run;
  assign bus.dbg_done   = (r_state == ST_DONE);

endmodule

// File: tb/tb_nibbler_ram_arbiter.sv
// Directed bench for nibbler_ram_arbiter with a behavioural 4Kx4 RAM (async read).
module tb_nibbler_ram_arbiter;

  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  nibbler_ram_arbiter_if bus ();

  nibbler_ram_arbiter #(.STARVE_LIMIT(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [3:0] mem [0:4095];
  assign bus.ram_rdata = mem[bus.ram_addr];
  always @(posedge clock) if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic quiet();
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = '0; bus.dbg_len = '0; bus.dbg_wdata = '0;
  endtask

  task automatic test_reset();
    reset = 0;
    quiet();
    @(negedge clock);
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 12'h123; bus.cpu_wdata = 4'h5;
    #1;
    checks++; if (bus.cpu_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b want 0", bus.cpu_gnt); end
    checks++; if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", bus.cpu_stall); end
    checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we: got %b want 0", bus.ram_we); end
    checks++; if (bus.ram_addr !== 12'h000) begin errors++; $display("FAIL reset_ram_addr: got %h want 000", bus.ram_addr); end
    checks++; if (bus.dbg_busy !== 1'b0 || bus.dbg_done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b%b want 00", bus.dbg_busy, bus.dbg_done); end
    checks++; if (bus.dbg_rvalid !== 1'b0 || bus.dbg_rdata !== 4'h0) begin errors++; $display("FAIL reset_rd: got %b/%h want 0/0", bus.dbg_rvalid, bus.dbg_rdata); end
    checks++; if (bus.dbg_wready !== 1'b0) begin errors++; $display("FAIL reset_wready: got %b want 0", bus.dbg_wready); end
    @(negedge clock);
    reset = 1;
    quiet();
  endtask

  task automatic test_cpu_access();
    logic [11:0] a [7] = '{12'hFFE, 12'hFFF, 12'h000, 12'h001, 12'h300, 12'h502, 12'h503};
    logic [3:0]  d [7] = '{4'h3, 4'h7, 4'h9, 4'hE, 4'h0, 4'h0, 4'h0};
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = a[i]; bus.cpu_wdata = d[i];
      #1;
      checks++;
      if (bus.cpu_gnt !== 1'b1 || bus.ram_we !== 1'b1 || bus.ram_addr !== a[i] || bus.cpu_stall !== 1'b0)
        begin errors++; $display("FAIL cpu_write[%0d]: gnt=%b we=%b addr=%h want 1/1/%h", i, bus.cpu_gnt, bus.ram_we, bus.ram_addr, a[i]); end
    end
    @(negedge clock);
    bus.cpu_we = 0; bus.cpu_addr = 12'hFFF;
    #1;
    checks++;
    if (bus.cpu_rdata !== 4'h7 || bus.ram_we !== 1'b0 || bus.cpu_gnt !== 1'b1)
      begin errors++; $display("FAIL cpu_read: rdata=%h we=%b gnt=%b want 7/0/1", bus.cpu_rdata, bus.ram_we, bus.cpu_gnt); end
    @(negedge clock);
    quiet();
  endtask

  task automatic test_write_burst();
    logic [3:0] d [3] = '{4'hA, 4'hB, 4'hC};
    int n_wr = 0, n_done = 0, done_c = -1;
    @(negedge clock);
    bus.dbg_req = 1; bus.dbg_we = 1; bus.dbg_addr = 12'h010; bus.dbg_len = 4'd3; bus.dbg_wdata = 4'hA;
    #1;
    checks++;
    if (bus.dbg_wready !== 1'b0 || bus.dbg_busy !== 1'b0)
      begin errors++; $display("FAIL wr_start: wready=%b busy=%b want 0/0", bus.dbg_wready, bus.dbg_busy); end
    for (int c = 1; c <= 5; c++) begin
      @(negedge clock);
      bus.dbg_req = 0;
      if (c <= 3) bus.dbg_wdata = d[c-1];
      #1;
      if (bus.dbg_wready === 1'b1) n_wr++;
      if (bus.dbg_done === 1'b1) begin n_done++; done_c = c; end
      if (c == 1) begin
        checks++;
        if (bus.ram_addr !== 12'h010 || bus.ram_we !== 1'b1)
          begin errors++; $display("FAIL wr_beat1: addr=%h we=%b want 010/1", bus.ram_addr, bus.ram_we); end
      end
    end
    checks++; if (n_wr != 3) begin errors++; $display("FAIL wr_wready_count: got %0d want 3", n_wr); end
    checks++; if (n_done != 1 || done_c != 4) begin errors++; $display("FAIL wr_done: pulses=%0d at %0d want 1 at 4", n_done, done_c); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem[12'h010 + i] !== d[i]) begin errors++; $display("FAIL wr_mem[%0d]: got %h want %h", i, mem[12'h010 + i], d[i]); end
    end
  endtask

  task automatic test_read_wrap();
    logic [3:0] e [4] = '{4'h3, 4'h7, 4'h9, 4'hE};
    int n_rv = 0, done_c = -1;
    @(negedge clock);
    bus.dbg_req = 1; bus.dbg_we = 0; bus.dbg_addr = 12'hFFE; bus.dbg_len = 4'd4;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clock);
      bus.dbg_req = 0;
      #1;
      if (bus.dbg_rvalid === 1'b1) begin
        checks++;
        if (n_rv >= 4 || c != n_rv + 2 || bus.dbg_rdata !== e[n_rv % 4])
          begin errors++; $display("FAIL rd_data[%0d]: got %h at cycle %0d want %h at %0d", n_rv, bus.dbg_rdata, c, e[n_rv % 4], n_rv + 2); end
        n_rv++;
      end
      if (bus.dbg_done === 1'b1) done_c = c;
      if (c == 3) begin
        checks++;
        if (bus.ram_addr !== 12'h000 || bus.ram_we !== 1'b0)
          begin errors++; $display("FAIL rd_wrap_addr: addr=%h we=%b want 000/0", bus.ram_addr, bus.ram_we); end
      end
    end
    checks++; if (n_rv != 4) begin errors++; $display("FAIL rd_rvalid_count: got %0d want 4", n_rv); end
    checks++; if (done_c != 5) begin errors++; $display("FAIL rd_done: got cycle %0d want 5", done_c); end
  endtask

  task automatic test_starve();
    int n_stall = 0, n_gnt = 0, done_c = -1;
    int st_c [2] = '{-1, -1};
    bus.dbg_we = 1; bus.dbg_addr = 12'h200; bus.dbg_len = 4'd2;
    bus.cpu_we = 1; bus.cpu_addr = 12'h300;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clock);
      bus.dbg_req   = (c == 0);
      bus.cpu_req   = (c <= 10);
      bus.cpu_wdata = 4'(c);
      bus.dbg_wdata = (n_stall == 0) ? 4'h1 : 4'h2;
      #1;
      if (bus.cpu_gnt === 1'b1) n_gnt++;
      if (bus.dbg_done === 1'b1) done_c = c;
      if (bus.cpu_stall === 1'b1) begin
        checks++;
        if (bus.ram_addr !== 12'h200 + 12'(n_stall) || bus.ram_we !== 1'b1 || bus.dbg_wready !== 1'b1)
          begin errors++; $display("FAIL starve_beat%0d: addr=%h we=%b wready=%b", n_stall, bus.ram_addr, bus.ram_we, bus.dbg_wready); end
        if (n_stall < 2) st_c[n_stall] = c;
        n_stall++;
      end
    end
    checks++; if (n_stall != 2) begin errors++; $display("FAIL starve_stall_count: got %0d want 2", n_stall); end
    checks++; if (st_c[0] != 5 || st_c[1] != 10) begin errors++; $display("FAIL starve_stall_cycles: got %0d,%0d want 5,10", st_c[0], st_c[1]); end
    checks++; if (n_gnt != 9) begin errors++; $display("FAIL starve_gnt_count: got %0d want 9", n_gnt); end
    checks++; if (done_c != 11) begin errors++; $display("FAIL starve_done: got cycle %0d want 11", done_c); end
    checks++; if (mem[12'h300] !== 4'h9) begin errors++; $display("FAIL starve_cpu_mem: got %h want 9", mem[12'h300]); end
    checks++;
    if (mem[12'h200] !== 4'h1 || mem[12'h201] !== 4'h2)
      begin errors++; $display("FAIL starve_dbg_mem: got %h,%h want 1,2", mem[12'h200], mem[12'h201]); end
    quiet();
  endtask

  task automatic test_len16_ignore();
    int n_wr = 0, done_c = -1;
    @(negedge clock);
    bus.dbg_req = 1; bus.dbg_we = 1; bus.dbg_addr = 12'h400; bus.dbg_len = 4'd0; bus.dbg_wdata = 4'h0;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clock);
      bus.dbg_req = (c >= 5 && c <= 7);
      if (c == 5) begin bus.dbg_addr = 12'h800; bus.dbg_len = 4'd1; bus.dbg_we = 0; end
      bus.dbg_wdata = 4'(c - 1);
      #1;
      if (bus.dbg_wready === 1'b1) n_wr++;
      if (bus.dbg_done === 1'b1) done_c = c;
      if (c == 6) begin
        checks++;
        if (bus.ram_addr !== 12'h405 || bus.ram_we !== 1'b1)
          begin errors++; $display("FAIL len16_ignore_req: addr=%h we=%b want 405/1", bus.ram_addr, bus.ram_we); end
      end
      if (c == 18) begin
        checks++;
        if (bus.dbg_busy !== 1'b0) begin errors++; $display("FAIL len16_no_restart: busy=%b want 0", bus.dbg_busy); end
      end
    end
    checks++; if (n_wr != 16) begin errors++; $display("FAIL len16_beats: got %0d want 16", n_wr); end
    checks++; if (done_c != 17) begin errors++; $display("FAIL len16_done: got cycle %0d want 17", done_c); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (mem[12'h400 + i] !== 4'(i)) begin errors++; $display("FAIL len16_mem[%0d]: got %h want %h", i, mem[12'h400 + i], 4'(i)); end
    end
    quiet();
  endtask

  task automatic test_simultaneous();
    @(negedge clock);
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 12'h100; bus.cpu_wdata = 4'h5;
    bus.dbg_req = 1; bus.dbg_we = 1; bus.dbg_addr = 12'h120; bus.dbg_len = 4'd1; bus.dbg_wdata = 4'h6;
    #1;
    checks++;
    if (bus.cpu_gnt !== 1'b1 || bus.ram_addr !== 12'h100 || bus.ram_we !== 1'b1 || bus.dbg_wready !== 1'b0)
      begin errors++; $display("FAIL simul_cpu: gnt=%b addr=%h we=%b wready=%b want 1/100/1/0", bus.cpu_gnt, bus.ram_addr, bus.ram_we, bus.dbg_wready); end
    @(negedge clock);
    bus.cpu_req = 0; bus.cpu_we = 0; bus.dbg_req = 0;
    #1;
    checks++;
    if (bus.dbg_wready !== 1'b1 || bus.ram_addr !== 12'h120) begin errors++; $display("FAIL simul_dbg_beat: wready=%b addr=%h want 1/120", bus.dbg_wready, bus.ram_addr); end
    checks++; if (mem[12'h100] !== 4'h5) begin errors++; $display("FAIL simul_cpu_mem: got %h want 5", mem[12'h100]); end
    @(negedge clock);
    #1;
    checks++; if (mem[12'h120] !== 4'h6) begin errors++; $display("FAIL simul_dbg_mem: got %h want 6", mem[12'h120]); end
    quiet();
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    bus.dbg_req = 1; bus.dbg_we = 1; bus.dbg_addr = 12'h500; bus.dbg_len = 4'd5; bus.dbg_wdata = 4'h1;
    @(negedge clock);
    bus.dbg_req = 0; bus.dbg_wdata = 4'h1;
    @(negedge clock);
    bus.dbg_wdata = 4'h2;
    @(negedge clock);
    reset = 0;
    bus.dbg_wdata = 4'h3;
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 12'h503; bus.cpu_wdata = 4'hF;
    #1;
    checks++;
    if (bus.cpu_gnt !== 1'b0 || bus.ram_we !== 1'b0 || bus.dbg_wready !== 1'b0 || bus.ram_addr !== 12'h000)
      begin errors++; $display("FAIL rstmid_forced: gnt=%b we=%b wready=%b addr=%h want 0/0/0/000", bus.cpu_gnt, bus.ram_we, bus.dbg_wready, bus.ram_addr); end
    checks++; if (bus.dbg_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", bus.dbg_busy); end
    @(negedge clock);
    #1;
    checks++;
    if (bus.dbg_rvalid !== 1'b0 || bus.dbg_done !== 1'b0 || bus.cpu_stall !== 1'b0)
      begin errors++; $display("FAIL rstmid_regs: rvalid=%b done=%b stall=%b want 0/0/0", bus.dbg_rvalid, bus.dbg_done, bus.cpu_stall); end
    reset = 1;
    quiet();
    @(negedge clock);
    #1;
    checks++;
    if (mem[12'h500] !== 4'h1 || mem[12'h501] !== 4'h2 || mem[12'h502] !== 4'h0 || mem[12'h503] !== 4'h0)
      begin errors++; $display("FAIL rstmid_mem: got %h %h %h %h want 1 2 0 0", mem[12'h500], mem[12'h501], mem[12'h502], mem[12'h503]); end
    checks++; if (bus.dbg_busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle: busy=%b want 0", bus.dbg_busy); end
    @(negedge clock);
    bus.dbg_req = 1; bus.dbg_we = 1; bus.dbg_addr = 12'h510; bus.dbg_len = 4'd1; bus.dbg_wdata = 4'h7;
    @(negedge clock);
    bus.dbg_req = 0;
    #1;
    checks++;
    if (bus.dbg_wready !== 1'b1 || bus.ram_addr !== 12'h510 || bus.ram_we !== 1'b1)
      begin errors++; $display("FAIL rstmid_new_beat: wready=%b addr=%h we=%b want 1/510/1", bus.dbg_wready, bus.ram_addr, bus.ram_we); end
    @(negedge clock);
    #1;
    checks++; if (bus.dbg_done !== 1'b1) begin errors++; $display("FAIL rstmid_new_done: got %b want 1", bus.dbg_done); end
    @(negedge clock);
    #1;
    checks++; if (mem[12'h510] !== 4'h7) begin errors++; $display("FAIL rstmid_new_mem: got %h want 7", mem[12'h510]); end
    quiet();
  endtask

  initial begin
    test_reset();
    test_cpu_access();
    test_write_burst();
    test_read_wrap();
    test_starve();
    test_len16_ignore();
    test_simultaneous();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
